// File: rtl/pulse_meter_if.sv
// Result channel of pulse_meter: one-entry valid/ready result register.
//   res_valid : a result is held (producer -> consumer)
//   res_ready : consumer accepts the held result (consumer -> producer)
//   res_width : measured width in cycles, saturated at MAX_LEN
//   res_ok    : width within expected window and not saturated
//   res_sat   : pulse reached MAX_LEN cycles
interface pulse_meter_if #(
  parameter int unsigned CW = 8
);
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_width;
  logic          res_ok;
  logic          res_sat;

  modport master (
    output res_valid,
    output res_width,
    output res_ok,
    output res_sat,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_width,
    input  res_ok,
    input  res_sat,
    output res_ready
  );
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures each high pulse on a synchronous line in clock cycles
// and classifies it against EXP_LEN +/- TOL. Results leave through a one-entry
// valid/ready register; a result that finds the register full is dropped and
// flagged in the sticky ovf bit.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   pulse_in   : pulse line to measure
//   clear      : synchronous clear of ovf (and of the statistics counters)
//   res        : result channel (pulse_meter_if.master)
//   ovf        : sticky, a result was dropped
//   busy       : a measurement is in progress
//   cnt_ok, cnt_bad, cnt_drop : 16-bit saturating statistics, present only
//                when PULSE_METER_STATS_EN is defined
module pulse_meter #(
  parameter int unsigned EXP_LEN = 8,
  parameter int unsigned TOL     = 0,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 clear,
  pulse_meter_if.master        res,
`ifdef PULSE_METER_STATS_EN
  output logic [15:0]          cnt_ok,
  output logic [15:0]          cnt_bad,
  output logic [15:0]          cnt_drop,
`endif
  output logic                 ovf,
  output logic                 busy
);

  localparam int unsigned CW = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN + 1);
  localparam logic [CW:0] LO_W  = (CW+1)'(EXP_LEN - TOL);
  localparam logic [CW:0] HI_W  = (CW+1)'(EXP_LEN + TOL);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_LEN);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEAS     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pin_q;
  logic          rise_c;
  logic          form_c;
  logic          drop_c;
  logic          sat_c;
  logic          ok_c;

  assign rise_c = pulse_in & ~pin_q;
  // A result forms on the first low sample while measuring.
  assign form_c = (state == MEAS) & ~pulse_in;
  assign drop_c = form_c & res.res_valid & ~res.res_ready;
  assign sat_c  = (cnt == MAX_W);
  // Window check one bit wider than the counter so EXP_LEN+TOL cannot wrap.
  assign ok_c   = ~sat_c & ({1'b0, cnt} >= LO_W) & ({1'b0, cnt} <= HI_W);

  // Next-state and width counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOW: begin
        if (!pulse_in) state_nxt = IDLE;
      end
      IDLE: begin
        if (rise_c) begin
          cnt_nxt   = CW'(1);
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (pulse_in) begin
          if (!sat_c) cnt_nxt = cnt + CW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  // State, input sample and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_q         <= 1'b1;
      state         <= WAIT_LOW;
      cnt           <= '0;
      res.res_valid <= 1'b0;
      res.res_width <= '0;
      res.res_ok    <= 1'b0;
      res.res_sat   <= 1'b0;
      ovf           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pin_q <= pulse_in;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == MEAS);

      if (form_c && !drop_c) begin
        res.res_valid <= 1'b1;
        res.res_width <= cnt;
        res.res_ok    <= ok_c;
        res.res_sat   <= sat_c;
      end else if (res.res_valid && res.res_ready) begin
        res.res_valid <= 1'b0;
      end

      // Drop beats clear on the same edge.
      if (drop_c)     ovf <= 1'b1;
      else if (clear) ovf <= 1'b0;
    end
  end

`ifdef PULSE_METER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics; an increment beats clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok   <= '0;
      cnt_bad  <= '0;
      cnt_drop <= '0;
    end else begin
      if (form_c && ok_c)       cnt_ok <= sat_inc(cnt_ok);
      else if (clear)           cnt_ok <= '0;

      if (form_c && !ok_c)      cnt_bad <= sat_inc(cnt_bad);
      else if (clear)           cnt_bad <= '0;

      if (drop_c)               cnt_drop <= sat_inc(cnt_drop);
      else if (clear)           cnt_drop <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter. Three instances share all inputs:
//   a: EXP_LEN=8 TOL=0 MAX_LEN=255
//   b: EXP_LEN=8 TOL=1 MAX_LEN=255
//   c: EXP_LEN=8 TOL=0 MAX_LEN=15
module tb_pulse_meter;

  logic clk;
  logic rst_n;
  logic pulse_in;
  logic clear;
  logic ready;

  int n_checks;
  int n_fails;

  logic ovf_a, ovf_b, ovf_c;
  logic busy_a, busy_b, busy_c;
`ifdef PULSE_METER_STATS_EN
  logic [15:0] ok_a, bad_a, drop_a;
  logic [15:0] ok_b, bad_b, drop_b;
  logic [15:0] ok_c, bad_c, drop_c;
`endif

  pulse_meter_if #(.CW(8)) if_a ();
  pulse_meter_if #(.CW(8)) if_b ();
  pulse_meter_if #(.CW(4)) if_c ();

  assign if_a.res_ready = ready;
  assign if_b.res_ready = ready;
  assign if_c.res_ready = ready;

  pulse_meter #(.EXP_LEN(8), .TOL(0), .MAX_LEN(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear), .res(if_a),
`ifdef PULSE_METER_STATS_EN
    .cnt_ok(ok_a), .cnt_bad(bad_a), .cnt_drop(drop_a),
`endif
    .ovf(ovf_a), .busy(busy_a)
  );

  pulse_meter #(.EXP_LEN(8), .TOL(1), .MAX_LEN(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear), .res(if_b),
`ifdef PULSE_METER_STATS_EN
    .cnt_ok(ok_b), .cnt_bad(bad_b), .cnt_drop(drop_b),
`endif
    .ovf(ovf_b), .busy(busy_b)
  );

  pulse_meter #(.EXP_LEN(8), .TOL(0), .MAX_LEN(15)) dut_c (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear), .res(if_c),
`ifdef PULSE_METER_STATS_EN
    .cnt_ok(ok_c), .cnt_bad(bad_c), .cnt_drop(drop_c),
`endif
    .ovf(ovf_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // High for w sampled edges, then one low sample; result visible on return.
  task automatic pulse(input int w);
    pulse_in = 1'b1;
    step(w);
    pulse_in = 1'b0;
    step(1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    ready    = 1'b1;

    // Reset state
    step(2);
    check("rst_valid", 32'(if_a.res_valid), 32'd0);
    check("rst_width", 32'(if_a.res_width), 32'd0);
    check("rst_ovf",   32'(ovf_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Nominal 8-cycle pulse
    pulse_in = 1'b1;
    step(7);
    check("p8_busy", 32'(busy_a), 32'd1);
    step(1);
    check("p8_not_yet", 32'(if_a.res_valid), 32'd0);
    pulse_in = 1'b0;
    step(1);
    check("p8_valid", 32'(if_a.res_valid), 32'd1);
    check("p8_width", 32'(if_a.res_width), 32'd8);
    check("p8_ok_a",  32'(if_a.res_ok), 32'd1);
    check("p8_sat_a", 32'(if_a.res_sat), 32'd0);
    check("p8_ok_b",  32'(if_b.res_ok), 32'd1);
    check("p8_ok_c",  32'(if_c.res_ok), 32'd1);
    check("p8_busy_off", 32'(busy_a), 32'd0);
    step(1);
    check("p8_accept", 32'(if_a.res_valid), 32'd0);

    // 7 then 9 with a single low cycle between
    pulse(7);
    check("p7_width", 32'(if_a.res_width), 32'd7);
    check("p7_ok_a",  32'(if_a.res_ok), 32'd0);
    check("p7_ok_b",  32'(if_b.res_ok), 32'd1);
    pulse(9);
    check("p9_valid", 32'(if_a.res_valid), 32'd1);
    check("p9_width", 32'(if_a.res_width), 32'd9);
    check("p9_ok_a",  32'(if_a.res_ok), 32'd0);
    check("p9_ok_b",  32'(if_b.res_ok), 32'd1);
    step(1);

    // 40-cycle pulse: saturates the MAX_LEN=15 instance only
    pulse_in = 1'b1;
    step(1);
    check("p40_busy_start", 32'(busy_c), 32'd1);
    step(38);
    check("p40_busy_mid", 32'(busy_c), 32'd1);
    step(1);
    pulse_in = 1'b0;
    step(1);
    check("p40_width_c", 32'(if_c.res_width), 32'd15);
    check("p40_sat_c",   32'(if_c.res_sat), 32'd1);
    check("p40_ok_c",    32'(if_c.res_ok), 32'd0);
    check("p40_width_a", 32'(if_a.res_width), 32'd40);
    check("p40_sat_a",   32'(if_a.res_sat), 32'd0);
    check("p40_busy_end", 32'(busy_c), 32'd0);
    step(1);

    // Overflow: consumer stalled, second result dropped
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    ready = 1'b0;
    pulse(8);
    check("ovf_first_w", 32'(if_a.res_width), 32'd8);
    step(1);
    pulse(5);
    check("ovf_held_v", 32'(if_a.res_valid), 32'd1);
    check("ovf_held_w", 32'(if_a.res_width), 32'd8);
    check("ovf_set",    32'(ovf_a), 32'd1);
`ifdef PULSE_METER_STATS_EN
    check("st_ok",   32'(ok_a), 32'd1);
    check("st_bad",  32'(bad_a), 32'd1);
    check("st_drop", 32'(drop_a), 32'd1);
`endif
    ready = 1'b1;
    step(1);
    check("ovf_drain_v", 32'(if_a.res_valid), 32'd0);
    check("ovf_sticky",  32'(ovf_a), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("ovf_clear", 32'(ovf_a), 32'd0);

    // Accept and new result on the same edge
    ready = 1'b0;
    pulse(6);
    check("same_first_w", 32'(if_a.res_width), 32'd6);
    pulse_in = 1'b1;
    step(3);
    pulse_in = 1'b0;
    ready = 1'b1;
    step(1);
    check("same_valid", 32'(if_a.res_valid), 32'd1);
    check("same_width", 32'(if_a.res_width), 32'd3);
    check("same_ovf",   32'(ovf_a), 32'd0);
    step(1);
    check("same_drain", 32'(if_a.res_valid), 32'd0);

    // Pulse already high at reset release is not measured
    rst_n = 1'b0;
    pulse_in = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(6);
    check("hi_rel_busy", 32'(busy_a), 32'd0);
    pulse_in = 1'b0;
    step(1);
    check("hi_rel_none", 32'(if_a.res_valid), 32'd0);
    pulse(8);
    check("hi_rel_v", 32'(if_a.res_valid), 32'd1);
    check("hi_rel_w", 32'(if_a.res_width), 32'd8);
    step(1);

    // Reset mid-pulse aborts with no result
    pulse_in = 1'b1;
    step(4);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_valid", 32'(if_a.res_valid), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    pulse_in = 1'b0;
    step(2);
    check("mid_no_result", 32'(if_a.res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
